// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the MINAv2 pipeline interlock controller.
// Register count and counter width are fixed here so every file agrees on them.
package hazard_ctrl_pkg;

    localparam int NUM_REGS = 32;
    localparam int PERF_W   = 32;

    typedef logic [4:0]          regaddr_t;
    typedef logic [NUM_REGS-1:0] scoreboard_t;
    typedef logic [PERF_W-1:0]   perf_cnt_t;

    localparam regaddr_t REG_ZERO = 5'd0;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic perf_cnt_t satInc(input perf_cnt_t value, input logic enable);
        return (enable && (value != '1)) ? value + perf_cnt_t'(1) : value;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX/WB side-band bundle between the pipeline stages and the interlock controller.
// The master is the pipeline (or a bench); the slave is hazard_ctrl.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic        id_valid;
    regaddr_t    id_ra_addr;
    regaddr_t    id_rb_addr;
    regaddr_t    id_rd_addr;
    logic        id_uses_ra;
    logic        id_uses_rb;
    logic        id_writes_rd;
    logic        wb_valid;
    regaddr_t    wb_rd_addr;
    logic        ex_branch_taken;
    logic        mem_busy;

    logic        if_stall;
    logic        id_stall;
    logic        issue;
    logic        ex_bubble;
    logic        flush_if_id;
    scoreboard_t pending_mask;
    perf_cnt_t   stall_count;
    perf_cnt_t   flush_count;

    modport master (
        output id_valid, id_ra_addr, id_rb_addr, id_rd_addr,
               id_uses_ra, id_uses_rb, id_writes_rd,
               wb_valid, wb_rd_addr, ex_branch_taken, mem_busy,
        input  if_stall, id_stall, issue, ex_bubble, flush_if_id,
               pending_mask, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_ra_addr, id_rb_addr, id_rd_addr,
               id_uses_ra, id_uses_rb, id_writes_rd,
               wb_valid, wb_rd_addr, ex_branch_taken, mem_busy,
        output if_stall, id_stall, issue, ex_bubble, flush_if_id,
               pending_mask, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// One pending bit per architectural register; r0 is never tracked.
// A set and a clear to the same register in one cycle resolves as set.
module hazard_ctrl_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_i,
    input  regaddr_t    set_addr_i,
    input  logic        clr_i,
    input  regaddr_t    clr_addr_i,
    input  regaddr_t    ra_addr_i,
    input  regaddr_t    rb_addr_i,
    input  regaddr_t    rd_addr_i,
    output logic        ra_pend_o,
    output logic        rb_pend_o,
    output logic        rd_pend_o,
    output scoreboard_t mask_o
);

    scoreboard_t pending_q;
    scoreboard_t pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign ra_pend_o = pending_q[ra_addr_i];
    assign rb_pend_o = pending_q[rb_addr_i];
    assign rd_pend_o = pending_q[rd_addr_i];
    assign mask_o    = pending_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock: stalls IF/ID on RAW/WAW hazards or memory busy, squashes ID on a
// taken branch, and keeps saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    hazard_ctrl_if.slave bus
);

    logic raPend;
    logic rbPend;
    logic rdPend;
    logic hazard;
    logic squash;
    logic freeze;
    logic issue;
    logic stall;
    logic setEn;

    perf_cnt_t stallCount_q;
    perf_cnt_t stallCount_d;
    perf_cnt_t flushCount_q;
    perf_cnt_t flushCount_d;

    hazard_ctrl_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (setEn),
        .set_addr_i (bus.id_rd_addr),
        .clr_i      (bus.wb_valid),
        .clr_addr_i (bus.wb_rd_addr),
        .ra_addr_i  (bus.id_ra_addr),
        .rb_addr_i  (bus.id_rb_addr),
        .rd_addr_i  (bus.id_rd_addr),
        .ra_pend_o  (raPend),
        .rb_pend_o  (rbPend),
        .rd_pend_o  (rdPend),
        .mask_o     (bus.pending_mask)
    );

    // r0 never hazards because its scoreboard bit is held at zero.
    assign hazard = bus.id_valid &&
                    ((bus.id_uses_ra   && raPend) ||
                     (bus.id_uses_rb   && rbPend) ||
                     (bus.id_writes_rd && rdPend));

    assign squash = bus.ex_branch_taken;
    assign freeze = bus.mem_busy;
    assign issue  = bus.id_valid && !hazard && !squash && !freeze;
    assign stall  = (hazard || freeze) && !squash;
    assign setEn  = issue && bus.id_writes_rd && (bus.id_rd_addr != REG_ZERO);

    assign bus.issue       = issue;
    assign bus.ex_bubble   = !issue;
    assign bus.if_stall    = stall;
    assign bus.id_stall    = stall;
    assign bus.flush_if_id = squash;

    always_comb begin
        stallCount_d = satInc(stallCount_q, stall);
        flushCount_d = satInc(flushCount_q, squash);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount_q <= '0;
            flushCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
            flushCount_q <= flushCount_d;
        end
    end

    assign bus.stall_count = stallCount_q;
    assign bus.flush_count = flushCount_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl: one row per clock with hand-computed
// expected control outputs, scoreboard mask and counters, plus an async-reset sequence.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        idValid;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic        usesRa;
        logic        usesRb;
        logic        writesRd;
        logic        wbValid;
        logic [4:0]  wbRd;
        logic        branch;
        logic        memBusy;
        logic        expStall;
        logic        expIssue;
        logic        expFlush;
        logic [31:0] expMask;
        logic [31:0] expStallCnt;
        logic [31:0] expFlushCnt;
    } vec_t;

    vec_t vecs [19];
    vec_t hand [3];

    function automatic vec_t mk(
        input logic idValid, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
        input logic usesRa, input logic usesRb, input logic writesRd,
        input logic wbValid, input logic [4:0] wbRd, input logic branch, input logic memBusy,
        input logic expStall, input logic expIssue, input logic expFlush,
        input logic [31:0] expMask, input logic [31:0] expStallCnt, input logic [31:0] expFlushCnt);
        vec_t v;
        v.idValid = idValid;   v.ra = ra;           v.rb = rb;         v.rd = rd;
        v.usesRa = usesRa;     v.usesRb = usesRb;   v.writesRd = writesRd;
        v.wbValid = wbValid;   v.wbRd = wbRd;       v.branch = branch; v.memBusy = memBusy;
        v.expStall = expStall; v.expIssue = expIssue; v.expFlush = expFlush;
        v.expMask = expMask;   v.expStallCnt = expStallCnt; v.expFlushCnt = expFlushCnt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.id_valid        = v.idValid;
        bus.id_ra_addr      = v.ra;
        bus.id_rb_addr      = v.rb;
        bus.id_rd_addr      = v.rd;
        bus.id_uses_ra      = v.usesRa;
        bus.id_uses_rb      = v.usesRb;
        bus.id_writes_rd    = v.writesRd;
        bus.wb_valid        = v.wbValid;
        bus.wb_rd_addr      = v.wbRd;
        bus.ex_branch_taken = v.branch;
        bus.mem_busy        = v.memBusy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkRow(input string tag, input vec_t v);
        checkOutput({tag, " if_stall"},     32'(bus.if_stall),    32'(v.expStall));
        checkOutput({tag, " id_stall"},     32'(bus.id_stall),    32'(v.expStall));
        checkOutput({tag, " issue"},        32'(bus.issue),       32'(v.expIssue));
        checkOutput({tag, " ex_bubble"},    32'(bus.ex_bubble),   32'(!v.expIssue));
        checkOutput({tag, " flush_if_id"},  32'(bus.flush_if_id), 32'(v.expFlush));
        checkOutput({tag, " pending_mask"}, bus.pending_mask,     v.expMask);
        checkOutput({tag, " stall_count"},  bus.stall_count,      v.expStallCnt);
        checkOutput({tag, " flush_count"},  bus.flush_count,      v.expFlushCnt);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Each row: inputs driven for one cycle; expectations hold before that cycle's edge.
        vecs[0]  = mk(1,1,2,3, 1,1,1, 0,0, 0,0,  0,1,0, 32'h00, 0,0);
        vecs[1]  = mk(1,3,0,4, 1,0,1, 0,0, 0,0,  1,0,0, 32'h08, 0,0);
        vecs[2]  = mk(1,3,0,4, 1,0,1, 1,3, 0,0,  1,0,0, 32'h08, 1,0);
        vecs[3]  = mk(1,3,0,4, 1,0,1, 0,0, 0,0,  0,1,0, 32'h00, 2,0);
        vecs[4]  = mk(1,0,0,0, 1,1,1, 0,0, 0,0,  0,1,0, 32'h10, 2,0);
        vecs[5]  = mk(1,0,0,0, 1,1,1, 0,0, 0,0,  0,1,0, 32'h10, 2,0);
        vecs[6]  = mk(1,1,2,4, 1,1,1, 0,0, 0,0,  1,0,0, 32'h10, 2,0);
        vecs[7]  = mk(1,1,2,4, 1,1,1, 1,4, 0,0,  1,0,0, 32'h10, 3,0);
        vecs[8]  = mk(1,1,2,4, 1,1,1, 0,0, 0,0,  0,1,0, 32'h00, 4,0);
        vecs[9]  = mk(1,4,0,6, 1,0,1, 0,0, 1,0,  0,0,1, 32'h10, 4,0);
        vecs[10] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0, 32'h10, 4,1);
        vecs[11] = mk(1,1,0,5, 1,0,1, 1,4, 0,1,  1,0,0, 32'h10, 4,1);
        vecs[12] = mk(1,1,0,5, 1,0,1, 0,0, 0,1,  1,0,0, 32'h00, 5,1);
        vecs[13] = mk(1,1,0,5, 1,0,1, 0,0, 0,1,  1,0,0, 32'h00, 6,1);
        vecs[14] = mk(1,1,0,5, 1,0,1, 0,0, 0,0,  0,1,0, 32'h00, 7,1);
        vecs[15] = mk(1,5,0,0, 1,0,0, 0,0, 1,1,  0,0,1, 32'h20, 7,1);
        vecs[16] = mk(1,1,2,6, 1,1,1, 1,6, 0,0,  0,1,0, 32'h20, 7,2);
        vecs[17] = mk(0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0, 32'h60, 7,2);
        vecs[18] = mk(1,5,6,0, 0,0,0, 0,0, 0,0,  0,1,0, 32'h60, 7,2);

        // Build pending = {r7, r3} while retiring r5/r6, then stall ID on r7.
        hand[0]  = mk(1,0,0,3, 0,0,1, 1,5, 0,0,  0,1,0, 32'h60, 7,2);
        hand[1]  = mk(1,0,0,7, 0,0,1, 1,6, 0,0,  0,1,0, 32'h48, 7,2);
        hand[2]  = mk(1,7,0,8, 1,0,1, 0,0, 0,0,  1,0,0, 32'h88, 7,2);

        rst_n = 1'b0;
        applyStimulus(mk(1,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0, 0,0,0));
        #3;
        checkOutput("reset issue", 32'(bus.issue), 32'd1);
        checkOutput("reset if_stall", 32'(bus.if_stall), 32'd0);
        checkOutput("reset pending_mask", bus.pending_mask, 32'h0);
        checkOutput("reset stall_count", bus.stall_count, 32'h0);
        bus.id_valid = 1'b0;
        #1;
        checkOutput("reset issue idle", 32'(bus.issue), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkRow($sformatf("row%0d", i), vecs[i]);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(hand[i]);
            #1;
            checkRow($sformatf("hand%0d", i), hand[i]);
        end

        // Asynchronous reset between edges while ID is stalled on r7.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset pending_mask", bus.pending_mask, 32'h0);
        checkOutput("areset stall_count", bus.stall_count, 32'h0);
        checkOutput("areset flush_count", bus.flush_count, 32'h0);
        checkOutput("areset issue", 32'(bus.issue), 32'd1);
        checkOutput("areset if_stall", 32'(bus.if_stall), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("areset held mask", bus.pending_mask, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post reset mask r8", bus.pending_mask, 32'h100);
        checkOutput("post reset stall_count", bus.stall_count, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
